// File: rtl/sm_trace_pkg.sv
// Shared definitions for the retired-instruction trace buffer:
// FSM state encodings and the width of one {pc, instr} record.
package sm_trace_pkg;

  localparam int TRC_REC_W = 64;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_e;

endpackage

// File: rtl/sm_trace_ram.sv
// Simple dual-port trace RAM: one write port and one registered read port.
// The array itself is not reset; only the read-output register is cleared.
module sm_trace_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read samples the array before this edge's write lands: same-address reads return old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sm_trace_buffer.sv
// Retired-instruction trace capture: circular buffer armed by the host,
// triggered on a PC match, frozen POST_TRIG records after the trigger.
module sm_trace_buffer
  import sm_trace_pkg::*;
#(
  parameter int DEPTH_W   = 5,
  parameter int POST_TRIG = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_valid,
  input  logic [31:0]          cpu_pc,
  input  logic [31:0]          cpu_instr,
  input  logic                 arm,
  input  logic                 trig_en,
  input  logic [31:0]          trig_pc,
  input  logic [DEPTH_W-1:0]   rd_addr,
  output logic [63:0]          rd_data,
  output logic [DEPTH_W:0]     count,
  output logic [1:0]           state,
  output logic                 done
);

  localparam logic [DEPTH_W:0]   DEPTH_C = (DEPTH_W+1)'(2**DEPTH_W);
  localparam logic [DEPTH_W-1:0] POST_C  = DEPTH_W'(POST_TRIG);

  trc_state_e          r_state;
  logic [DEPTH_W-1:0]  r_wr_ptr;
  logic [DEPTH_W:0]    r_count;
  logic [DEPTH_W-1:0]  r_post_cnt;
  logic                r_done;

  logic                w_capturing;
  logic                w_we;
  logic                w_trig_hit;
  logic [DEPTH_W-1:0]  w_rd_idx;
  logic [DEPTH_W:0]    w_count_inc;

  assign w_capturing = (r_state == TRC_ARMED) || (r_state == TRC_POST);
  // arm wins over a same-cycle retire, so that record is never written.
  assign w_we        = w_capturing && cpu_valid && !arm;
  assign w_trig_hit  = trig_en && (cpu_pc == trig_pc);
  assign w_count_inc = (r_count == DEPTH_C) ? r_count : r_count + 1'b1;
  // Oldest record sits count slots behind the write pointer; natural DEPTH_W-bit wrap.
  assign w_rd_idx    = r_wr_ptr - r_count[DEPTH_W-1:0] + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TRC_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post_cnt <= '0;
      r_done     <= 1'b0;
    end else if (arm) begin
      r_state    <= TRC_ARMED;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        TRC_ARMED: begin
          if (cpu_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= w_count_inc;
            if (w_trig_hit) begin
              if (POST_TRIG == 0) begin
                r_state <= TRC_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state    <= TRC_POST;
                r_post_cnt <= POST_C;
              end
            end
          end
        end
        TRC_POST: begin
          if (cpu_valid) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_count    <= w_count_inc;
            r_post_cnt <= r_post_cnt - 1'b1;
            if (r_post_cnt == DEPTH_W'(1)) begin
              r_state <= TRC_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sm_trace_ram #(
    .ADDR_W (DEPTH_W),
    .DATA_W (TRC_REC_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({cpu_pc, cpu_instr}),
    .i_raddr (w_rd_idx),
    .o_rdata (rd_data)
  );

  assign count = r_count;
  assign state = r_state;
  assign done  = r_done;

endmodule
